uart_imem_loader: RTL and testbench

- Parametrised UART boot loader between the host serial link and the core's instruction memory.
- Hunts for the ASCII unlock key "TECTUINNO", then receives a length-prefixed, checksummed program image.
- Packs received bytes into WORD_BYTES-wide words, writes them sequentially into imem, and holds the CPU in reset until the load succeeds.
- Replies ACK/NAK on tx; the next generation of the fixed-width byte-to-imem loader.

---
 rtl/uart_loader_pkg.sv | 24 ++
 rtl/uart_loader_phy.sv | 115 +++++++++++
 rtl/uart_imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        REPLY
    } state_e;

    localparam int KEY_LEN = 9;

    // "TECTUINNO"
    localparam logic [7:0] KEY [KEY_LEN] = '{
        8'h54, 8'h45, 8'h43, 8'h54, 8'h55,
        8'h49, 8'h4E, 8'h4E, 8'h4F
    };

    localparam logic [7:0] ACK_BYTE = 8'h4B;
    localparam logic [7:0] NAK_BYTE = 8'h45;

endpackage

// File: rtl/uart_loader_phy.sv
// 8N1 UART receive and transmit engines with a two-flop rx synchroniser.
module uart_phy #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_act_q, rx_valid_q, rx_ferr_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          tx_act_q, tx_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_sh_q;

    assign rx_s     = sync_q[1];
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_byte  = rx_sh_q;
    assign tx_busy  = tx_act_q;
    assign tx       = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end

    // rx_bit_q: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_act_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            if (!rx_act_q) begin
                if (!rx_s) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                end
            end else if (rx_bit_q == 4'd0) begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    if (rx_s) rx_act_q <= 1'b0;
                    else      rx_bit_q <= 4'd1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            end else if (rx_cnt_q != FULL) begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end else begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd9) begin
                    rx_act_q   <= 1'b0;
                    rx_valid_q <= rx_s;
                    rx_ferr_q  <= !rx_s;
                end else begin
                    rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_act_q <= 1'b0;
            tx_q     <= 1'b1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
        end else if (!tx_act_q) begin
            if (tx_start) begin
                tx_act_q <= 1'b1;
                tx_q     <= 1'b0;
                tx_sh_q  <= {1'b1, tx_byte};
                tx_cnt_q <= '0;
                tx_bit_q <= '0;
            end
        end else if (tx_cnt_q != FULL) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_act_q <= 1'b0;
            end else begin
                tx_q     <= tx_sh_q[0];
                tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                tx_bit_q <= tx_bit_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Serial boot loader: key hunt, length-prefixed image, word packing into imem.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ      = 27_000_000,
    parameter int BAUD        = 115_200,
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH       = 1024,
    parameter int TIMEOUT_CYC = 27_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    output logic                          imem_we,
    output logic [$clog2(DEPTH)-1:0]      imem_addr,
    output logic [8*WORD_BYTES-1:0]       imem_wdata,
    output logic                          cpu_hold,
    output logic                          load_done,
    output logic                          load_err,
    output logic                          busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DW = 8 * WORD_BYTES;
    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic              rx_valid, rx_ferr, tx_busy, tx_start;
    logic [7:0]        rx_byte;
    state_e            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [15:0]       len_q, len_d, wcnt_q, wcnt_d, n_w;
    logic [LW-1:0]     lane_q, lane_d;
    logic [DW-1:0]     buf_q, buf_d, wdata_q, wdata_d, nb;
    logic [7:0]        csum_q, csum_d, reply_q, reply_d;
    logic [31:0]       to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, hold_q, hold_d;
    logic              done_q, done_d, err_q, err_d;
    logic              loading, timeout;

    uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr),
        .tx_start (tx_start),
        .tx_byte  (reply_q),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    assign loading = state_q inside {LEN_LO, LEN_HI, DATA, CSUM};
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout = loading && !rx_valid && (to_q >= 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            k_q     <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
            lane_q  <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            reply_q <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            reply_q <= reply_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        reply_d = reply_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        nb      = buf_q;
        n_w     = {rx_byte, len_q[7:0]};
        to_d    = (rx_valid || !loading) ? 32'd0 : to_q + 32'd1;
        if (we_q && addr_q != LAST) addr_d = addr_q + 1'b1;
        unique case (state_q)
            HUNT: if (rx_valid) begin
                if (rx_byte == KEY[k_q]) begin
                    if (k_q == 4'(KEY_LEN - 1)) begin
                        k_d     = '0;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        csum_d  = '0;
                        addr_d  = '0;
                        state_d = LEN_LO;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    k_d = (rx_byte == KEY[0]) ? 4'd1 : 4'd0;
                end
            end
            LEN_LO: if (rx_valid) begin
                len_d[7:0] = rx_byte;
                state_d    = LEN_HI;
            end
            LEN_HI: if (rx_valid) begin
                len_d  = n_w;
                wcnt_d = '0;
                lane_d = '0;
                if (32'(n_w) > DEPTH) begin
                    err_d   = 1'b1;
                    reply_d = NAK_BYTE;
                    state_d = REPLY;
                end else if (n_w == 16'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (rx_valid) begin
                nb[8*lane_q +: 8] = rx_byte;
                buf_d  = nb;
                csum_d = csum_q + rx_byte;
                if (lane_q == LW'(WORD_BYTES - 1)) begin
                    lane_d  = '0;
                    wdata_d = nb;
                    we_d    = 1'b1;
                    wcnt_d  = wcnt_q + 16'd1;
                    if (wcnt_q + 16'd1 == len_q) state_d = CSUM;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            CSUM: if (rx_valid) begin
                state_d = REPLY;
                if (rx_byte == csum_q) begin
                    reply_d = ACK_BYTE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    reply_d = NAK_BYTE;
                    err_d   = 1'b1;
                end
            end
            REPLY: if (!tx_busy) state_d = HUNT;
            default: state_d = HUNT;
        endcase
        if (loading && (rx_ferr || timeout)) begin
            err_d   = 1'b1;
            reply_d = NAK_BYTE;
            state_d = REPLY;
        end
    end

    always_comb begin
        tx_start = (state_q == REPLY) && !tx_busy;
        busy     = (state_q != HUNT);
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader with a word-level load model.
module tb_uart_imem_loader;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int WB     = 4;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int TO     = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx, imem_we, cpu_hold, load_done, load_err, busy;
    logic [AW-1:0]   imem_addr;
    logic [8*WB-1:0] imem_wdata;

    int n_run  = 0;
    int n_fail = 0;
    logic [7:0]         tx_got [$];
    logic [AW+8*WB-1:0] wr_q   [$];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORD_BYTES(WB),
        .DEPTH(DEPTH), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    always @(negedge clk)
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});

    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(posedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                tx_got.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        repeat ($urandom_range(4, 0)) @(posedge clk);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_hdr(input int n);
        send_str("TECTUINNO");
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic wait_reply(output logic [7:0] b);
        b = 8'hxx;
        for (int i = 0; i < 3 * TO; i++) begin
            @(posedge clk);
            if (tx_got.size() > 0) begin
                b = tx_got.pop_front();
                return;
            end
        end
    endtask

    function automatic logic [AW+8*WB-1:0] got_wr(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 'x;
    endfunction

    // Reference: word i is bytes i*WB.. little-endian, written at address i.
    function automatic logic [AW+8*WB-1:0] model_wr(input logic [7:0] img [$], input int i);
        logic [31:0] w = 0;
        for (int b = 0; b < WB; b++) w = w + (32'(img[i*WB+b]) << (8 * b));
        return {AW'(i), w};
    endfunction

    function automatic logic [7:0] model_csum(input logic [7:0] img [$]);
        int s = 0;
        foreach (img[i]) s = s + img[i];
        return 8'(s % 256);
    endfunction

    task automatic clear_q;
        wr_q.delete();
        tx_got.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_run++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx); end
        n_run++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", imem_we); end
        n_run++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        n_run++; if (imem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
        n_run++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got=%b exp=1", cpu_hold); end
        n_run++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", load_done); end
        n_run++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", load_err); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_unlock;
        logic [7:0] r;
        clear_q();
        send_str("TECTTECTUINN");
        @(negedge clk);
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unlock_busy_early got=%b exp=0", busy); end
        send_byte("O");
        @(negedge clk);
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL unlock_busy got=%b exp=1", busy); end
        n_run++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL unlock_hold got=%b exp=1", cpu_hold); end
        n_run++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL unlock_err got=%b exp=0", load_err); end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_reply(r);
        n_run++; if (r !== 8'h4B) begin n_fail++; $display("FAIL zero_len_reply got=%h exp=4b", r); end
        n_run++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL zero_len_writes got=%0d exp=0", wr_q.size()); end
        n_run++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL zero_len_done got=%b exp=1", load_done); end
        n_run++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_len_hold got=%b exp=0", cpu_hold); end
    endtask

    task automatic test_no_unlock;
        clear_q();
        send_str("TECTUINNX");
        repeat (20 * CPB) @(posedge clk);
        @(negedge clk);
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nokey_busy got=%b exp=0", busy); end
        n_run++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL nokey_hold got=%b exp=0", cpu_hold); end
        n_run++; if (tx_got.size() != 0) begin n_fail++; $display("FAIL nokey_tx got=%0d exp=0", tx_got.size()); end
    endtask

    task automatic test_spec_image(input bit good);
        logic [7:0] img [$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic [7:0] r;
        clear_q();
        send_hdr(2);
        foreach (img[i]) send_byte(img[i]);
        send_byte(good ? 8'hB6 : 8'h00);
        wait_reply(r);
        n_run++; if (r !== (good ? 8'h4B : 8'h45)) begin n_fail++; $display("FAIL img%0d_reply got=%h exp=%h", good, r, good ? 8'h4B : 8'h45); end
        n_run++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL img%0d_nwr got=%0d exp=2", good, wr_q.size()); end
        n_run++; if (got_wr(0) !== {4'd0, 32'h00000013}) begin n_fail++; $display("FAIL img%0d_w0 got=%h exp=000000013", good, got_wr(0)); end
        n_run++; if (got_wr(1) !== {4'd1, 32'h00100093}) begin n_fail++; $display("FAIL img%0d_w1 got=%h exp=100100093", good, got_wr(1)); end
        n_run++; if (load_done !== good) begin n_fail++; $display("FAIL img%0d_done got=%b exp=%b", good, load_done, good); end
        n_run++; if (load_err !== !good) begin n_fail++; $display("FAIL img%0d_err got=%b exp=%b", good, load_err, !good); end
        n_run++; if (cpu_hold !== !good) begin n_fail++; $display("FAIL img%0d_hold got=%b exp=%b", good, cpu_hold, !good); end
    endtask

    task automatic test_overflow;
        logic [7:0] r;
        clear_q();
        send_hdr(DEPTH + 1);
        wait_reply(r);
        n_run++; if (r !== 8'h45) begin n_fail++; $display("FAIL ovf_reply got=%h exp=45", r); end
        repeat (10 * CPB) @(posedge clk);
        n_run++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL ovf_writes got=%0d exp=0", wr_q.size()); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random_loads;
        for (int it = 0; it < 3; it++) begin
            logic [7:0] img [$];
            logic [7:0] r, cs;
            int n;
            bit good;
            clear_q();
            n = (it == 0) ? DEPTH : int'($urandom_range(6, 1));
            good = (it == 0) ? 1'b1 : (it == 1) ? 1'b0 : 1'($urandom_range(1, 0));
            for (int i = 0; i < n * WB; i++) img.push_back(8'($urandom));
            cs = good ? model_csum(img) : model_csum(img) ^ 8'h5A;
            send_hdr(n);
            foreach (img[i]) send_byte(img[i]);
            send_byte(cs);
            wait_reply(r);
            n_run++; if (r !== (good ? 8'h4B : 8'h45)) begin n_fail++; $display("FAIL rnd%0d_reply got=%h good=%b", it, r, good); end
            n_run++; if (wr_q.size() != n) begin n_fail++; $display("FAIL rnd%0d_nwr got=%0d exp=%0d", it, wr_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                n_run++;
                if (got_wr(i) !== model_wr(img, i)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_word%0d got=%h exp=%h", it, i, got_wr(i), model_wr(img, i));
                end
            end
            n_run++; if (imem_addr !== AW'((n < DEPTH) ? n : DEPTH - 1)) begin n_fail++; $display("FAIL rnd%0d_addr got=%0d n=%0d", it, imem_addr, n); end
            n_run++; if (load_done !== good) begin n_fail++; $display("FAIL rnd%0d_done got=%b exp=%b", it, load_done, good); end
            n_run++; if (cpu_hold !== !good) begin n_fail++; $display("FAIL rnd%0d_hold got=%b exp=%b", it, cpu_hold, !good); end
        end
    endtask

    task automatic test_timeout;
        logic [7:0] r;
        clear_q();
        send_hdr(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_reply(r);
        n_run++; if (r !== 8'h45) begin n_fail++; $display("FAIL tmo_reply got=%h exp=45", r); end
        n_run++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got=%b exp=1", load_err); end
        n_run++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL tmo_hold got=%b exp=1", cpu_hold); end
        n_run++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL tmo_writes got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_framing;
        logic [7:0] r;
        clear_q();
        send_str("TECTUINNO");
        send_byte(8'h01);
        send_byte(8'h00, 1'b0);
        wait_reply(r);
        n_run++; if (r !== 8'h45) begin n_fail++; $display("FAIL ferr_reply got=%h exp=45", r); end
        n_run++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL ferr_err got=%b exp=1", load_err); end
        repeat (4 * CPB) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        clear_q();
        send_hdr(2);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_run++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        n_run++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we got=%b exp=0", imem_we); end
        n_run++; if (imem_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr got=%h exp=0", imem_addr); end
        n_run++; if (imem_wdata !== '0) begin n_fail++; $display("FAIL rstmid_wdata got=%h exp=0", imem_wdata); end
        n_run++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold got=%b exp=1", cpu_hold); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        n_run++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL rstmid_writes got=%0d exp=1", wr_q.size()); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_no_unlock();
        test_spec_image(1'b1);
        test_spec_image(1'b0);
        test_overflow();
        test_random_loads();
        test_timeout();
        test_framing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
